// File: rtl/psdsqrt_pkg.sv
// Shared definitions for the sequential square-root core: FSM states,
// default operand configuration and the configuration legality check.
package psdsqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } psdsqrt_state_e;

   localparam int PSDSQRT_XW_DEF  = 32;
   localparam int PSDSQRT_BPC_DEF = 1;

   // True when the operand width is even and in range, and the root width
   // splits into a whole number of iterations of bpc bits each.
   function automatic bit psdsqrt_widths_ok(input int xw, input int bpc);
      return (xw % 2 == 0) && (xw >= 4) && (xw <= 64) &&
             ((bpc == 1) || (bpc == 2)) && (((xw / 2) % bpc) == 0);
   endfunction

endpackage

// File: rtl/psdsqrt_step.sv
// One restoring square-root digit step: brings two operand bits into the
// partial remainder, tries subtracting (root<<2)|1 and resolves one root bit.
module psdsqrt_step #(
   parameter int RW = 16
) (
   input  logic [RW+1:0] rem_in,
   input  logic [RW-1:0] root_in,
   input  logic [1:0]    x_bits,
   output logic [RW+1:0] rem_out,
   output logic [RW-1:0] root_out
);

   logic [RW+1:0] rem_sh;
   logic [RW+1:0] trial;
   logic          take;

   // The incoming remainder never exceeds 2*root < 2^RW, so its two MSBs
   // are always zero and can be dropped by the shift; likewise the root MSB
   // is still zero until the final step.
   logic unused_bits;
   assign unused_bits = ^{rem_in[RW+1:RW], root_in[RW-1]};

   // Trial subtraction and root-bit decision
   always_comb begin
      rem_sh   = {rem_in[RW-1:0], x_bits};
      trial    = {root_in, 2'b01};
      take     = (rem_sh >= trial);
      rem_out  = take ? (rem_sh - trial) : rem_sh;
      root_out = {root_in[RW-2:0], take};
   end

endmodule

// File: rtl/psdsqrt_param.sv
// Sequential integer square root with start/busy/done handshake.
// root = floor(sqrt(xin)), rem = xin - root^2, BPC root bits per cycle.
// Optional build macro PSDSQRT_ROUND_EN: root rounds to nearest
// (saturating at all-ones); rem always reports the truncated remainder.
module psdsqrt_param
   import psdsqrt_pkg::*;
#(
   parameter int XW  = PSDSQRT_XW_DEF,
   parameter int BPC = PSDSQRT_BPC_DEF
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [XW-1:0]   xin,
   output logic            busy,
   output logic            done,
   output logic [XW/2-1:0] root,
   output logic [XW/2:0]   rem
);

   localparam int RW = XW / 2;
   localparam int K  = RW / BPC;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   generate
      if (!psdsqrt_widths_ok(XW, BPC)) begin : g_bad_cfg
         $error("psdsqrt_param: illegal XW/BPC combination");
      end
   endgenerate

   psdsqrt_state_e state_reg, state_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic [XW-1:0]  x_reg, x_next;
   logic [RW+1:0]  remp_reg, remp_next;
   logic [RW-1:0]  rootp_reg, rootp_next;
   logic [RW-1:0]  root_reg, root_next;
   logic [RW:0]    rem_reg, rem_next;

   logic [RW+1:0]  rem_chain  [0:BPC];
   logic [RW-1:0]  root_chain [0:BPC];
   logic [RW-1:0]  root_final;

   assign rem_chain[0]  = remp_reg;
   assign root_chain[0] = rootp_reg;

   // BPC chained steps consume the top 2*BPC bits of the operand register
   genvar gi;
   generate
      for (gi = 0; gi < BPC; gi++) begin : g_step
         psdsqrt_step #(.RW(RW)) u_step (
            .rem_in   (rem_chain[gi]),
            .root_in  (root_chain[gi]),
            .x_bits   (x_reg[XW-1-2*gi -: 2]),
            .rem_out  (rem_chain[gi+1]),
            .root_out (root_chain[gi+1])
         );
      end
   endgenerate

   // The final remainder is at most 2*root, so it fits in RW+1 bits
   logic unused_rem_msb;
   assign unused_rem_msb = rem_chain[BPC][RW+1];

`ifdef PSDSQRT_ROUND_EN
   // Round to nearest: xin - r^2 > r means xin is past (r+0.5)^2
   always_comb begin
      root_final = root_chain[BPC];
      if ((rem_chain[BPC][RW:0] > {1'b0, root_chain[BPC]}) && !(&root_chain[BPC]))
         root_final = root_chain[BPC] + 1'b1;
   end
`else
   // Truncated root is the result as-is
   always_comb begin
      root_final = root_chain[BPC];
   end
`endif

   // State, iteration and result registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         x_reg     <= '0;
         remp_reg  <= '0;
         rootp_reg <= '0;
         root_reg  <= '0;
         rem_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         x_reg     <= x_next;
         remp_reg  <= remp_next;
         rootp_reg <= rootp_next;
         root_reg  <= root_next;
         rem_reg   <= rem_next;
      end
   end

   // Next-state: accept in IDLE/DONE, iterate in CALC, publish on last step
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      x_next     = x_reg;
      remp_next  = remp_reg;
      rootp_next = rootp_reg;
      root_next  = root_reg;
      rem_next   = rem_reg;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next = CALC;
               x_next     = xin;
               remp_next  = '0;
               rootp_next = '0;
               cnt_next   = CW'(K - 1);
            end else begin
               state_next = IDLE;
            end
         end
         CALC: begin
            x_next     = x_reg << (2 * BPC);
            remp_next  = rem_chain[BPC];
            rootp_next = root_chain[BPC];
            if (cnt_reg == '0) begin
               state_next = DONE;
               root_next  = root_final;
               rem_next   = rem_chain[BPC][RW:0];
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state_reg == CALC);
   assign done = (state_reg == DONE);
   assign root = root_reg;
   assign rem  = rem_reg;

endmodule

// File: tb/tb_psdsqrt_param.sv
// Directed bench for psdsqrt_param: three instances (XW=32/BPC=1,
// XW=32/BPC=2, XW=16/BPC=1) share clock, reset, start and operand.
// Latencies are counted in edges including the accepting edge.
module tb_psdsqrt_param;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] xin   = '0;

   logic        busy0, done0, busy1, done1, busy2, done2;
   logic [15:0] root0, root1;
   logic [16:0] rem0, rem1;
   logic [7:0]  root2;
   logic [8:0]  rem2;

   int n_vec = 0;
   int n_err = 0;

`ifdef PSDSQRT_ROUND_EN
   localparam int ROUND = 1;
`else
   localparam int ROUND = 0;
`endif

   always #5 clock = ~clock;

   psdsqrt_param #(.XW(32), .BPC(1)) u_dut0 (
      .clock(clock), .reset(reset), .start(start), .xin(xin),
      .busy(busy0), .done(done0), .root(root0), .rem(rem0));
   psdsqrt_param #(.XW(32), .BPC(2)) u_dut1 (
      .clock(clock), .reset(reset), .start(start), .xin(xin),
      .busy(busy1), .done(done1), .root(root1), .rem(rem1));
   psdsqrt_param #(.XW(16), .BPC(1)) u_dut2 (
      .clock(clock), .reset(reset), .start(start), .xin(xin[15:0]),
      .busy(busy2), .done(done2), .root(root2), .rem(rem2));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Floor square root via floating point, corrected by exact integer checks
   function automatic longint isqrt(input longint v);
      longint r;
      r = longint'($sqrt(real'(v)));
      while (r * r > v) r--;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   function automatic longint exp_root(input longint v, input int rw);
      longint r;
      r = isqrt(v);
      if ((ROUND != 0) && (v - r * r > r) && (r < (64'd1 << rw) - 1)) r++;
      return r;
   endfunction

   // Drive start for one edge; returns #1 after the accepting edge
   task automatic start_op(input logic [31:0] x);
      @(negedge clock);
      start = 1'b1;
      xin   = x;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   // Wait for all three done pulses, bounded; latency 0 means timeout
   task automatic wait_all(output int lat0, output int lat1, output int lat2, output int busyc);
      lat0 = 0; lat1 = 0; lat2 = 0;
      busyc = busy0 ? 1 : 0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clock);
         #1;
         if (busy0) busyc++;
         if (done0 && lat0 == 0) lat0 = e + 1;
         if (done1 && lat1 == 0) lat1 = e + 1;
         if (done2 && lat2 == 0) lat2 = e + 1;
         if (lat0 != 0 && lat1 != 0 && lat2 != 0) break;
      end
   endtask

   task automatic run_and_check(input string tag, input logic [31:0] x);
      int l0, l1, l2, bc;
      longint v16;
      start_op(x);
      wait_all(l0, l1, l2, bc);
      v16 = longint'(x[15:0]);
      check({tag, " root32b1"}, 64'(root0), 64'(exp_root(longint'(x), 16)));
      check({tag, " rem32b1"},  64'(rem0),  64'(longint'(x) - isqrt(longint'(x)) ** 2));
      check({tag, " root32b2"}, 64'(root1), 64'(exp_root(longint'(x), 16)));
      check({tag, " rem32b2"},  64'(rem1),  64'(longint'(x) - isqrt(longint'(x)) ** 2));
      check({tag, " root16"},   64'(root2), 64'(exp_root(v16, 8)));
      check({tag, " rem16"},    64'(rem2),  64'(v16 - isqrt(v16) ** 2));
   endtask

   initial begin
      int l0, l1, l2, bc, pulses;
      logic seen;

      // Reset state while reset is held low
      #12;
      check("rst busy", 64'(busy0), 64'd0);
      check("rst done", 64'(done0), 64'd0);
      check("rst root", 64'(root0), 64'd0);
      check("rst rem",  64'(rem0),  64'd0);
      #11 reset = 1'b1;

      // Zero operand with latency and busy-width checks
      start_op(32'd0);
      wait_all(l0, l1, l2, bc);
      check("x0 root", 64'(root0), 64'd0);
      check("x0 rem",  64'(rem0),  64'd0);
      check("x0 lat32b1", 64'(l0), 64'd17);
      check("x0 lat32b2", 64'(l1), 64'd9);
      check("x0 lat16",   64'(l2), 64'd9);
      check("x0 busy cycles", 64'(bc), 64'd16);

      // Hand-computed directed vectors
      start_op(32'hFFFF_FFFF);
      wait_all(l0, l1, l2, bc);
      check("xmax root", 64'(root0), 64'd65535);
      check("xmax rem",  64'(rem0),  64'd131070);
      check("xmax root b2", 64'(root1), 64'd65535);
      check("xmax rem b2",  64'(rem1),  64'd131070);

      start_op(32'd24);
      wait_all(l0, l1, l2, bc);
      check("x24 root", 64'(root0), (ROUND != 0) ? 64'd5 : 64'd4);
      check("x24 rem",  64'(rem0),  64'd8);
      check("x24 root16", 64'(root2), (ROUND != 0) ? 64'd5 : 64'd4);

      start_op(32'd20);
      wait_all(l0, l1, l2, bc);
      check("x20 root", 64'(root0), 64'd4);
      check("x20 rem",  64'(rem0),  64'd4);

      // Power-of-two sweep against the model
      for (int i = 0; i < 32; i++) begin
         run_and_check($sformatf("pow%0d", i), 32'd1 << i);
         run_and_check($sformatf("powp%0d", i), (32'd1 << i) + 32'(i));
      end

      // start pulsed at cycle 5 of CALC with a different operand is ignored
      start_op(32'd1000);
      repeat (4) @(posedge clock);
      @(negedge clock);
      start = 1'b1;
      xin   = 32'd5000;
      @(posedge clock);
      #1;
      start = 1'b0;
      xin   = '0;
      seen  = 1'b0;
      for (int e = 0; e < 30; e++) begin
         @(posedge clock);
         #1;
         if (done0) begin
            seen = 1'b1;
            break;
         end
      end
      check("ignore done seen", 64'(seen), 64'd1);
      check("ignore root", 64'(root0), (ROUND != 0) ? 64'd32 : 64'd31);
      check("ignore rem",  64'(rem0),  64'd39);

      // start held in the DONE cycle is accepted without an idle gap
      check("b2b in done", 64'(done0), 64'd1);
      start_op(32'd144);
      check("b2b busy", 64'(busy0), 64'd1);
      wait_all(l0, l1, l2, bc);
      check("b2b lat", 64'(l0), 64'd17);
      check("b2b root", 64'(root0), 64'd12);
      check("b2b rem",  64'(rem0),  64'd0);

      // Asynchronous reset mid-CALC, between clock edges
      start_op(32'd1000);
      repeat (5) @(posedge clock);
      #3 reset = 1'b0;
      #1;
      check("arst busy", 64'(busy0), 64'd0);
      check("arst done", 64'(done0), 64'd0);
      check("arst root", 64'(root0), 64'd0);
      check("arst rem",  64'(rem0),  64'd0);
      #3 reset = 1'b1;
      pulses = 0;
      for (int e = 0; e < 30; e++) begin
         @(posedge clock);
         #1;
         if (done0 || busy0) pulses++;
      end
      check("arst no activity", 64'(pulses), 64'd0);
      start_op(32'd20);
      wait_all(l0, l1, l2, bc);
      check("arst after root", 64'(root0), 64'd4);
      check("arst after rem",  64'(rem0),  64'd4);
      check("arst after lat",  64'(l0),    64'd17);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/psdsqrt_param.md
# psdsqrt_param

Parametrised sequential integer square-root unit, the next generation of the lab square-root calculator. Computes root = floor(sqrt(xin)) and remainder = xin − root² by restoring digit-by-digit iteration over an even input width, producing 1 or 2 root bits per cycle. It uses a start/busy/done handshake instead of the start/stop protocol of the previous block, and sits as a stand-alone arithmetic core driven by a controller or testbench.

## Interface
- XW, 32, input operand width; even, 4..64
- BPC, 1, root bits resolved per clock cycle; 1 or 2; (XW/2) divisible by BPC
- RW (localparam), XW/2, root width
- clock  in  1  master clock, positive edge
- reset  in  1  asynchronous, active-low master reset (clears all state while low)
- start  in  1  request; sampled on posedge; accepted only in IDLE or DONE
- xin  in  XW  operand; captured on the accepting edge, ignored otherwise
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse; root/rem valid from this cycle
- root  out  RW  result, held until next completion
- rem  out  RW+1  remainder xin − root² (truncated root), held with root

## Operation
- States: IDLE, CALC, DONE. IDLE --start--> CALC; CALC --last iteration--> DONE; DONE --start--> CALC, else --> IDLE.
- Accept: x register ← xin; partial remainder ← 0; partial root ← 0; iteration counter ← K−1, where K = RW/BPC.
- Each CALC cycle runs BPC chained steps. Per step:
  - Shift two MSBs of x into the partial remainder (RW+2 bits).
  - Compute trial = (partial_root<<2)|1.
  - If remainder ≥ trial: remainder −= trial and root bit = 1; else root bit = 0.
  - partial_root = (partial_root<<1)|bit.
- start during CALC is ignored; xin is not re-sampled.
- Outputs root/rem load only on the CALC→DONE edge. They are never cleared by a new start.
- reset low at any time, including mid-CALC: state → IDLE, busy=0, done=0, root=0, rem=0, counter=0. No partial result escapes.

## Timing
- Accepting edge E0: busy=1 after E0.
- Iterations occur on edges E1..EK. On EK, root/rem update, busy→0, done→1.
- done is high for exactly the cycle after EK.
- Latency start→done = K+1 edges. XW=32: 17 edges at BPC=1, 9 at BPC=2.
- Back-to-back: start high in the DONE cycle is accepted on that edge. Throughput is one result per K+1 cycles.
- Reset values: busy=0, done=0, root=0, rem=0.

## Configuration
- PSDSQRT_ROUND_EN defined: root rounds to nearest. If rem > truncated root, output root+1, saturating at all-ones (2^RW−1). rem still reports the truncated-root remainder. Adds no latency.
- Undefined: root is floor(sqrt(xin)).

## Structure
- Package psdsqrt_pkg holds:
  - the state enum (IDLE, CALC, DONE)
  - the width-check helper function
  - the default XW/BPC constants
- Sub-module psdsqrt_step: purely combinational single-bit iteration (remainder in, root in, 2 x bits → remainder out, root out). Instantiated BPC times in a generate chain.
- Elaboration-time check that XW is even and RW mod BPC = 0.

## Test plan
- XW=32, BPC=1: xin=0 → root=0, rem=0; done exactly 17 edges after the accepting edge; busy high 16 cycles.
- xin=0xFFFFFFFF → root=65535, rem=131070. With PSDSQRT_ROUND_EN, root stays 65535 (saturated).
- xin=24 → root=4, rem=8; with ROUND_EN root=5. xin=20 → root=4, rem=4 under both builds.
- Sweep 1<<i and (1<<i)+i for i=0..31 against a software floor-sqrt model. Repeat at BPC=2 (done 9 edges after accept) and XW=16.
- start pulsed again at cycle 5 of CALC with a different xin: ignored, first result unchanged. start held in the DONE cycle: second operation accepted, no idle gap.
- reset driven low asynchronously mid-CALC (between clock edges): busy/done/root/rem read 0 immediately. After release, no done pulse until a new start.
